// File: rtl/dcache_pkg.sv
// Shared types and address geometry for the direct-mapped write-back data cache.
package dcache_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WRITEBACK,
    REFILL
  } state_e;

  localparam int LINE_W     = 256;
  localparam int OFFSET_W   = 5;
  localparam int WORD_SEL_W = 3;
  localparam int WORD_W     = 32;

  function automatic int index_width(input int lines);
    return $clog2(lines);
  endfunction

  function automatic int tag_width(input int addr_w, input int lines);
    return addr_w - OFFSET_W - $clog2(lines);
  endfunction

endpackage

// File: rtl/dcache_sram.sv
// Line storage: valid/dirty/tag/data arrays with one combinational read port
// and one synchronous full-line write port sharing the same index.
module dcache_sram
  import dcache_pkg::*;
#(
  parameter int LINES = 16,
  parameter int TAG_W = 23
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [$clog2(LINES)-1:0] index,
  output logic                     rd_valid,
  output logic                     rd_dirty,
  output logic [TAG_W-1:0]         rd_tag,
  output logic [LINE_W-1:0]        rd_data,
  input  logic                     wr_en,
  input  logic                     wr_valid,
  input  logic                     wr_dirty,
  input  logic [TAG_W-1:0]         wr_tag,
  input  logic [LINE_W-1:0]        wr_data
);

  logic [LINES-1:0]  valid_q;
  logic [LINES-1:0]  dirty_q;
  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [LINE_W-1:0] data_q [LINES];

  assign rd_valid = valid_q[index];
  assign rd_dirty = dirty_q[index];
  assign rd_tag   = tag_q[index];
  assign rd_data  = data_q[index];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (wr_en) begin
      valid_q[index] <= wr_valid;
      dirty_q[index] <= wr_dirty;
    end
  end

  // NOTE: tag and data arrays have no reset; a cleared valid bit makes their contents irrelevant.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      tag_q[index]  <= wr_tag;
      data_q[index] <= wr_data;
    end
  end

endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped write-back/write-allocate data cache: zero-latency hits,
// pipeline stall while an IDLE/WRITEBACK/REFILL FSM services misses.
module dcache_controller
  import dcache_pkg::*;
#(
  parameter int LINES  = 16,
  parameter int ADDR_W = 32
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [ADDR_W-1:0]   cpu_addr_i,
  input  logic [WORD_W-1:0]   cpu_data_i,
  input  logic                cpu_MemRead_i,
  input  logic                cpu_MemWrite_i,
  output logic [WORD_W-1:0]   cpu_data_o,
  output logic                cpu_stall_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [LINE_W-1:0]   mem_data_o,
  output logic                mem_enable_o,
  output logic                mem_write_o,
  input  logic [LINE_W-1:0]   mem_data_i,
  input  logic                mem_ack_i
);

  localparam int IDX_W = index_width(LINES);
  localparam int TAG_W = tag_width(ADDR_W, LINES);

  state_e state_q, state_d;

  logic [OFFSET_W-1:0]   offset;
  logic [WORD_SEL_W-1:0] word_sel;
  logic [IDX_W-1:0]      index;
  logic [TAG_W-1:0]      tag;
  logic                  req, hit;

  logic                  rd_valid, rd_dirty;
  logic [TAG_W-1:0]      rd_tag;
  logic [LINE_W-1:0]     rd_data;
  logic [WORD_W-1:0]     rd_word;
  logic [LINE_W-1:0]     merged;

  logic                  wr_en, wr_valid, wr_dirty;
  logic [TAG_W-1:0]      wr_tag;
  logic [LINE_W-1:0]     wr_data;

  assign offset   = cpu_addr_i[OFFSET_W-1:0];
  assign word_sel = WORD_SEL_W'(offset >> 2);
  assign index    = cpu_addr_i[OFFSET_W +: IDX_W];
  assign tag      = cpu_addr_i[ADDR_W-1 -: TAG_W];

  // A pipeline being reset presents no request, so stall/data stay 0 during reset.
  assign req = (cpu_MemRead_i | cpu_MemWrite_i) & ~rst_i;
  assign hit = rd_valid && (rd_tag == tag);

  assign rd_word = rd_data[{word_sel, 5'b0} +: WORD_W];

  always_comb begin
    merged = rd_data;
    merged[{word_sel, 5'b0} +: WORD_W] = cpu_data_i;
  end

  dcache_sram #(
    .LINES (LINES),
    .TAG_W (TAG_W)
  ) u_sram (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .index    (index),
    .rd_valid (rd_valid),
    .rd_dirty (rd_dirty),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data),
    .wr_en    (wr_en),
    .wr_valid (wr_valid),
    .wr_dirty (wr_dirty),
    .wr_tag   (wr_tag),
    .wr_data  (wr_data)
  );

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d      = state_q;
    cpu_stall_o  = 1'b0;
    cpu_data_o   = '0;
    mem_enable_o = 1'b0;
    mem_write_o  = 1'b0;
    mem_addr_o   = '0;
    mem_data_o   = '0;
    wr_en        = 1'b0;
    wr_valid     = 1'b1;
    wr_dirty     = 1'b1;
    wr_tag       = tag;
    wr_data      = merged;

    unique case (state_q)
      IDLE: begin
        if (req) begin
          if (hit) begin
            // Both strobes high is a store.
            if (cpu_MemWrite_i) wr_en = 1'b1;
            else                cpu_data_o = rd_word;
          end else begin
            cpu_stall_o = 1'b1;
            state_d     = (rd_valid && rd_dirty) ? WRITEBACK : REFILL;
          end
        end
      end
      WRITEBACK: begin
        cpu_stall_o  = 1'b1;
        mem_enable_o = 1'b1;
        mem_write_o  = 1'b1;
        mem_addr_o   = {rd_tag, index, {OFFSET_W{1'b0}}};
        mem_data_o   = rd_data;
        if (mem_ack_i) state_d = REFILL;
      end
      REFILL: begin
        cpu_stall_o  = 1'b1;
        mem_enable_o = 1'b1;
        mem_addr_o   = {tag, index, {OFFSET_W{1'b0}}};
        if (mem_ack_i) begin
          wr_en    = 1'b1;
          wr_dirty = 1'b0;
          wr_data  = mem_data_i;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_dcache_controller.sv
// Scoreboard bench for dcache_controller: directed accesses push expected
// CPU responses and memory transactions; monitors pop and compare.
module tb_dcache_controller;
  import dcache_pkg::*;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic [31:0]  cpu_addr_i;
  logic [31:0]  cpu_data_i;
  logic         cpu_MemRead_i;
  logic         cpu_MemWrite_i;
  logic [31:0]  cpu_data_o;
  logic         cpu_stall_o;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_data_o;
  logic         mem_enable_o;
  logic         mem_write_o;
  logic [255:0] mem_data_i;
  logic         mem_ack_i;

  dcache_controller #(.LINES(16), .ADDR_W(32)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .cpu_addr_i     (cpu_addr_i),
    .cpu_data_i     (cpu_data_i),
    .cpu_MemRead_i  (cpu_MemRead_i),
    .cpu_MemWrite_i (cpu_MemWrite_i),
    .cpu_data_o     (cpu_data_o),
    .cpu_stall_o    (cpu_stall_o),
    .mem_addr_o     (mem_addr_o),
    .mem_data_o     (mem_data_o),
    .mem_enable_o   (mem_enable_o),
    .mem_write_o    (mem_write_o),
    .mem_data_i     (mem_data_i),
    .mem_ack_i      (mem_ack_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [31:0] data;
    int          stall;
    int          mem_cyc;
  } cpu_exp_t;

  typedef struct packed {
    logic         write;
    logic [31:0]  addr;
    logic [255:0] line;
  } mem_exp_t;

  cpu_exp_t cpu_q[$];
  mem_exp_t mem_q[$];

  int checks   = 0;
  int failures = 0;
  int wb_lat   = 1;
  int rf_lat   = 1;

  logic [255:0] mem_store [logic [31:0]];
  logic [255:0] line100;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Default memory contents: word w of line a is {a[15:0], 8'h5A, w}.
  function automatic logic [255:0] pattern_line(input logic [31:0] a);
    logic [255:0] l;
    for (int w = 0; w < 8; w++) l[w*32 +: 32] = {a[15:0], 8'h5A, 8'(w)};
    return l;
  endfunction

  function automatic logic [255:0] with_word(input logic [255:0] l, input int w, input logic [31:0] v);
    logic [255:0] r;
    r = l;
    r[w*32 +: 32] = v;
    return r;
  endfunction

  function automatic logic [255:0] mem_line(input logic [31:0] a);
    if (mem_store.exists(a)) return mem_store[a];
    return pattern_line(a);
  endfunction

  task automatic expect_mem(input logic wr, input logic [31:0] addr, input logic [255:0] line);
    mem_exp_t e;
    e.write = wr;
    e.addr  = addr;
    e.line  = line;
    mem_q.push_back(e);
  endtask

  // Issue one access at posedge+1, hold it until stall drops, return at the next posedge+1.
  task automatic access(input logic [31:0] addr, input logic rd, input logic wr,
                        input logic [31:0] wdata, input logic [31:0] exp_data,
                        input int exp_stall, input int exp_mem);
    cpu_exp_t e;
    int  n;
    bit  done;
    e.data    = exp_data;
    e.stall   = exp_stall;
    e.mem_cyc = exp_mem;
    cpu_q.push_back(e);
    cpu_addr_i     = addr;
    cpu_MemRead_i  = rd;
    cpu_MemWrite_i = wr;
    cpu_data_i     = wdata;
    n    = 0;
    done = 1'b0;
    while (!done && n < 200) begin
      @(negedge clk_i);
      n++;
      if (!cpu_stall_o) done = 1'b1;
    end
    check("access_completes", done, 1'b1);
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle(input int n);
    cpu_MemRead_i  = 1'b0;
    cpu_MemWrite_i = 1'b0;
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_stall"}, cpu_stall_o, 1'b0);
    check({tag, "_cpu_data"}, cpu_data_o, 32'h0);
    check({tag, "_mem_enable"}, mem_enable_o, 1'b0);
    check({tag, "_mem_write"}, mem_write_o, 1'b0);
    check({tag, "_mem_addr"}, mem_addr_o, 32'h0);
    check({tag, "_mem_data"}, mem_data_o, 256'h0);
  endtask

  // Memory responder: acks the Nth enabled cycle of each request; a cycle
  // following an ack with enable still high starts a new request.
  initial begin
    int cnt;
    int lat;
    cnt        = 0;
    mem_ack_i  = 1'b0;
    mem_data_i = '0;
    forever begin
      @(posedge clk_i);
      #2;
      if (rst_i || !mem_enable_o) begin
        mem_ack_i = 1'b0;
        cnt       = 0;
      end else begin
        if (mem_ack_i) cnt = 0;
        cnt++;
        lat = mem_write_o ? wb_lat : rf_lat;
        if (cnt >= lat) begin
          mem_ack_i = 1'b1;
          if (mem_write_o) mem_store[mem_addr_o] = mem_data_o;
          else             mem_data_i = mem_line(mem_addr_o);
        end else begin
          mem_ack_i = 1'b0;
        end
      end
    end
  end

  // Monitor: compares memory requests every enabled cycle and CPU responses
  // whenever a request completes (stall low).
  initial begin
    int       stall_cnt;
    int       mem_cyc;
    cpu_exp_t ce;
    mem_exp_t me;
    stall_cnt = 0;
    mem_cyc   = 0;
    forever begin
      @(negedge clk_i);
      if (rst_i) begin
        cpu_q.delete();
        mem_q.delete();
        stall_cnt = 0;
        mem_cyc   = 0;
      end else begin
        if (mem_enable_o) begin
          if (mem_q.size() == 0) begin
            check("mem_unexpected_request", mem_enable_o, 1'b0);
          end else begin
            me = mem_q[0];
            check("mem_write", mem_write_o, me.write);
            check("mem_addr", mem_addr_o, me.addr);
            if (mem_ack_i) begin
              if (me.write) check("mem_wb_line", mem_data_o, me.line);
              void'(mem_q.pop_front());
            end
          end
        end
        if (cpu_MemRead_i || cpu_MemWrite_i) begin
          if (cpu_stall_o) begin
            stall_cnt++;
            if (mem_enable_o) mem_cyc++;
          end else begin
            if (cpu_q.size() == 0) begin
              check("cpu_unexpected_response", cpu_q.size(), 1);
            end else begin
              ce = cpu_q.pop_front();
              check("cpu_data", cpu_data_o, ce.data);
              check("stall_cycles", stall_cnt, ce.stall);
              check("mem_enable_cycles", mem_cyc, ce.mem_cyc);
            end
            stall_cnt = 0;
            mem_cyc   = 0;
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    line100 = with_word(with_word(pattern_line(32'h100), 1, 32'hDEAD_BEEF), 2, 32'h0BAD_F00D);
    mem_store[32'h100] = line100;

    rst_i          = 1'b1;
    cpu_addr_i     = '0;
    cpu_data_i     = '0;
    cpu_MemRead_i  = 1'b0;
    cpu_MemWrite_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    check_outputs_zero("reset");
    @(negedge clk_i);
    rst_i = 1'b0;
    @(posedge clk_i);
    #1;

    // Cold load miss, ack on the 10th enabled cycle.
    rf_lat = 10;
    expect_mem(1'b0, 32'h0000_0100, '0);
    access(32'h0000_0104, 1'b1, 1'b0, 32'h0, 32'hDEAD_BEEF, 11, 10);

    // Hit in the filled line.
    access(32'h0000_0108, 1'b1, 1'b0, 32'h0, 32'h0BAD_F00D, 0, 0);

    // Store miss to index 0: fill, then merge and dirty.
    rf_lat = 4;
    expect_mem(1'b0, 32'h0000_0200, '0);
    access(32'h0000_0200, 1'b0, 1'b1, 32'h1234_5678, 32'h0, 5, 4);
    access(32'h0000_0200, 1'b1, 1'b0, 32'h0, 32'h1234_5678, 0, 0);

    // Dirty eviction: writeback 0x200 (3 cycles) then refill 0x400 (2 cycles).
    wb_lat = 3;
    rf_lat = 2;
    expect_mem(1'b1, 32'h0000_0200, with_word(pattern_line(32'h200), 0, 32'h1234_5678));
    expect_mem(1'b0, 32'h0000_0400, '0);
    access(32'h0000_0400, 1'b1, 1'b0, 32'h0, 32'h0400_5A00, 6, 5);

    // Dirty the new line, then evict it with k1 = k2 = 1.
    access(32'h0000_0400, 1'b0, 1'b1, 32'h55AA_33CC, 32'h0, 0, 0);
    wb_lat = 1;
    rf_lat = 1;
    expect_mem(1'b1, 32'h0000_0400, with_word(pattern_line(32'h400), 0, 32'h55AA_33CC));
    expect_mem(1'b0, 32'h0000_0600, '0);
    access(32'h0000_0604, 1'b1, 1'b0, 32'h0, 32'h0600_5A01, 3, 2);

    // Back-to-back hits on different lines.
    access(32'h0000_0104, 1'b1, 1'b0, 32'h0, 32'hDEAD_BEEF, 0, 0);
    access(32'h0000_0604, 1'b1, 1'b0, 32'h0, 32'h0600_5A01, 0, 0);
    access(32'h0000_0108, 1'b1, 1'b0, 32'h0, 32'h0BAD_F00D, 0, 0);
    idle(2);

    // Reset while waiting in REFILL.
    rf_lat = 30;
    expect_mem(1'b0, 32'h0000_0800, '0);
    cpu_addr_i    = 32'h0000_0804;
    cpu_MemRead_i = 1'b1;
    repeat (5) @(posedge clk_i);
    #3;
    check("pre_reset_stall", cpu_stall_o, 1'b1);
    check("pre_reset_enable", mem_enable_o, 1'b1);
    rst_i = 1'b1;
    #1;
    check("reset_enable_drop", mem_enable_o, 1'b0);
    check("reset_stall_drop", cpu_stall_o, 1'b0);
    cpu_MemRead_i = 1'b0;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    @(posedge clk_i);
    #1;

    // The line that hit earlier is invalid again.
    rf_lat = 3;
    expect_mem(1'b0, 32'h0000_0100, '0);
    access(32'h0000_0104, 1'b1, 1'b0, 32'h0, 32'hDEAD_BEEF, 4, 3);

    // Read and write both high on a hit: a store.
    access(32'h0000_0108, 1'b1, 1'b1, 32'hCAFE_F00D, 32'h0, 0, 0);
    access(32'h0000_0108, 1'b1, 1'b0, 32'h0, 32'hCAFE_F00D, 0, 0);
    wb_lat = 2;
    rf_lat = 2;
    expect_mem(1'b1, 32'h0000_0100, with_word(line100, 2, 32'hCAFE_F00D));
    expect_mem(1'b0, 32'h0000_0300, '0);
    access(32'h0000_0300, 1'b1, 1'b0, 32'h0, 32'h0300_5A00, 5, 4);

    idle(3);
    check("cpu_queue_drained", cpu_q.size(), 0);
    check("mem_queue_drained", mem_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dcache_controller.md
# dcache_controller

Direct-mapped, write-back, write-allocate data cache placed between the CPU's MEM stage and a slow line-wide data memory. Load/store hits complete in the MEM cycle with no stall. Misses stall the whole pipeline while a three-state FSM writes back a dirty victim line and then refills the line.

## Interface
- `LINES`, default 16: number of cache lines (power of two).
- `ADDR_W`, default 32: CPU byte-address width.
- `clk_i`, in, 1: the one clock.
- `rst_i`, in, 1: reset, asynchronous and active-high.
- `cpu_addr_i`, in, 32: byte address from the EX/MEM ALU result.
- `cpu_data_i`, in, 32: store data.
- `cpu_MemRead_i`, in, 1: load request.
- `cpu_MemWrite_i`, in, 1: store request.
- `cpu_data_o`, out, 32: load data, valid when `cpu_stall_o` is 0.
- `cpu_stall_o`, out, 1: freezes PC and all pipeline registers.
- `mem_addr_o`, out, 32: line-aligned memory address.
- `mem_data_o`, out, 256: victim line being written back.
- `mem_enable_o`, out, 1: memory request active.
- `mem_write_o`, out, 1: 1 = write, 0 = read.
- `mem_data_i`, in, 256: refill line.
- `mem_ack_i`, in, 1: one-cycle pulse that completes the current request.

## Operation
- **Address split (LINES=16):**
  - offset = addr[4:0]; word select = addr[4:2].
  - index = addr[8:5].
  - tag = addr[31:9] (23 bits).
  - Generally, index is log2(LINES) bits and tag is ADDR_W−5−log2(LINES) bits.
- **Per-line state:** valid bit, dirty bit, tag, and 256 bits of data.
- **Request:** `cpu_MemRead_i | cpu_MemWrite_i`. If both are high, treat it as a write. No request means no stall and no state change.
- **Hit** (valid and tag equal), in state IDLE:
  - Read: `cpu_data_o` = selected word, combinationally, in the same cycle.
  - Write: at the clock edge, merge the word into the line and set dirty.
  - `cpu_stall_o` = 0.
- **Miss:** `cpu_stall_o` = 1, combinationally, in the same cycle. The CPU holds its address, data and control stable while stalled.
- **FSM states:** IDLE, WRITEBACK, REFILL.
  - IDLE, request misses, victim valid and dirty → WRITEBACK.
  - IDLE, request misses, otherwise → REFILL.
  - WRITEBACK: enable=1, write=1, addr = {victim tag, index, 5'b0}, data = victim line. On `mem_ack_i` → REFILL.
  - REFILL: enable=1, write=0, addr = {cpu tag, index, 5'b0}. On `mem_ack_i`, write `mem_data_i` into the line at that edge, set valid=1, dirty=0, tag=cpu tag → IDLE.
  - In IDLE the request is re-evaluated and now hits. A store miss therefore merges its word and sets dirty in that hit cycle.
- **Outside WRITEBACK/REFILL:** `mem_enable_o`=0, `mem_write_o`=0, `mem_addr_o`=0, `mem_data_o`=0.
- **`cpu_stall_o`** = (state ≠ IDLE) | (IDLE & request & miss).
- **`cpu_data_o`** = 0 when there is no read hit.

## Timing
- **Reset values:** all outputs 0; state IDLE; every valid and dirty bit cleared. Tag and data contents are don't-care.
- **Reset mid-miss:** the request is abandoned, and `mem_enable_o` falls asynchronously with reset.
- **Hit latency:** 0 extra cycles.
- **Clean miss:**
  - The miss is detected in cycle N and the FSM is in REFILL from N+1.
  - If ack arrives in cycle N+k, then N+k+1 is the hit cycle.
  - Stall is high for k+1 cycles.
- **Dirty miss:** the writeback takes k1 cycles and the refill k2 cycles, so stall is high for 1+k1+k2 cycles.
- **Memory handshake:**
  - `mem_addr_o`, `mem_write_o` and `mem_data_o` are stable while enable is high until ack.
  - Enable may stay high straight from WRITEBACK into REFILL. The memory treats the cycle after an ack, with enable still high, as a new request.
  - Ack outside WRITEBACK/REFILL is ignored.
  - Ack in the same cycle the request starts is legal (k=1).
- **Consecutive accesses:** back-to-back hits to different lines sustain one access per cycle. A miss to the same index as the line just filled is handled as a fresh miss.

## Structure
- **Shared package `dcache_pkg`:**
  - State enum (IDLE, WRITEBACK, REFILL).
  - `LINE_W` = 256, `OFFSET_W` = 5, `WORD_SEL_W` = 3.
  - Field-extraction constants for tag/index.
- **Sub-module `dcache_sram`:**
  - Arrays of valid, dirty, tag and data.
  - One combinational read port by index.
  - One synchronous write port: full line plus valid/dirty/tag.
  - Asynchronous clear of valid/dirty on `rst_i`.
- **`dcache_controller` itself:** FSM, tag compare, word select/merge, memory-port muxing.

## Test plan
- **Cold load miss:**
  - Stimulus: reset, load 0x0000_0104, memory acks after 10 cycles with line word1 = 0xDEAD_BEEF.
  - Required: stall high for exactly 11 cycles; `mem_addr_o` = 0x0000_0100, write=0; then `cpu_data_o` = 0xDEAD_BEEF with stall 0.
- **Hit after fill:**
  - Stimulus: load 0x0000_0108 from the same line.
  - Required: stall 0 in the same cycle; data is word2 of the line; `mem_enable_o` stays 0.
- **Store miss then dirty eviction:**
  - Stimulus: store 0x1234_5678 to 0x0000_0200 (index 0). Then load 0x0000_0400 (index 0, different tag).
  - Required, first: line filled, then marked dirty.
  - Required, second: WRITEBACK to 0x0000_0200 with the line holding 0x1234_5678 in word0, write=1. Then REFILL from 0x0000_0400.
  - Required, stall: 1+k1+k2 cycles.
- **Continuous enable across states:**
  - Stimulus: dirty miss with ack at k1=1 and k2=1.
  - Required: enable high for 2 consecutive cycles, the address changes after the first ack, and stall lasts 3 cycles.
- **Reset during REFILL:**
  - Stimulus: assert `rst_i` mid-wait.
  - Required: `mem_enable_o` and `cpu_stall_o` drop immediately. A subsequent load of the earlier-hit 0x0000_0104 misses, because valid was cleared.
- **Both MemRead and MemWrite high on a hit:**
  - Required: treated as a store; dirty set; `cpu_data_o` = 0.
